// File: rtl/cdr_frame_sync.sv
// ============================================================================
// Module   : cdr_frame_sync
// Brief    : Sync-word hunt/confirm/lock framer for a CDR bit stream; deframes
//            payload MSB-first into bytes and keeps sync/frame debug counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdr_frame_sync #(
  parameter int                SYNC_W      = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hF628,
  parameter int                FRAME_BYTES = 4,
  parameter int                MAX_MISS    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic        bit_in,
  input  logic        clr,
  output logic        locked,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_start,
  output logic [7:0]  sync_err_cnt,
  output logic [15:0] frame_cnt
);

  localparam int c_PAY_BITS  = FRAME_BYTES * 8;
  localparam int c_FRAME_LEN = c_PAY_BITS + SYNC_W;
  localparam int c_CNT_W     = $clog2(c_FRAME_LEN + 1);
  localparam int c_FILL_W    = $clog2(SYNC_W + 1);

  localparam logic [c_CNT_W-1:0]  c_FRAME_LEN_V = c_CNT_W'(c_FRAME_LEN);
  localparam logic [c_CNT_W-1:0]  c_PAY_BITS_V  = c_CNT_W'(c_PAY_BITS);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL   = c_FILL_W'(SYNC_W);
  localparam logic [c_FILL_W-1:0] c_FILL_THR    = c_FILL_W'(SYNC_W - 1);
  localparam logic [3:0]          c_MAX_MISS_V  = 4'(MAX_MISS);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Only SYNC_W-1 history bits are kept; the incoming bit completes the window.
  logic [SYNC_W-2:0]   r_sr;
  logic [c_FILL_W-1:0] r_fill;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic [3:0]          r_miss;
  logic [6:0]          r_byte_sr;
  logic                r_locked;
  logic [7:0]          r_byte_data;
  logic                r_byte_valid;
  logic                r_frame_start;
  logic [7:0]          r_sync_err_cnt;
  logic [15:0]         r_frame_cnt;

  logic [SYNC_W-1:0]   w_nsr;
  logic                w_match;
  logic [c_CNT_W-1:0]  w_idx;
  logic                w_at_end;
  logic                w_pay;
  logic                w_byte_end;
  logic                w_fill_ok;
  logic [3:0]          w_miss_inc;
  logic                w_drop;

  logic                w_lock_ok;
  logic                w_sync_good;
  logic                w_sync_bad;
  logic                w_to_hunt;

  assign w_nsr      = {r_sr, bit_in};
  assign w_match    = (w_nsr == SYNC_WORD);
  assign w_idx      = r_bit_cnt + 1'b1;
  assign w_at_end   = (w_idx == c_FRAME_LEN_V);
  assign w_pay      = (w_idx <= c_PAY_BITS_V);
  assign w_byte_end = w_pay && (w_idx[2:0] == 3'd0);
  assign w_fill_ok  = (r_fill >= c_FILL_THR);
  assign w_miss_inc = r_miss + 1'b1;
  assign w_drop     = (w_miss_inc >= c_MAX_MISS_V);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_HUNT;
      r_locked <= 1'b0;
    end else if (clr) begin
      r_state  <= S_HUNT;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and sync-check decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_lock_ok   = 1'b0;
    w_sync_good = 1'b0;
    w_sync_bad  = 1'b0;
    w_to_hunt   = 1'b0;
    if (sample_en) begin
      case (r_state)
        S_HUNT: begin
          if (w_fill_ok && w_match) begin
            w_state_nxt = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (w_at_end) begin
            if (w_match) begin
              w_state_nxt = S_LOCKED;
              w_lock_ok   = 1'b1;
            end else begin
              w_state_nxt = S_HUNT;
              w_to_hunt   = 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (w_at_end) begin
            if (w_match) begin
              w_sync_good = 1'b1;
            end else begin
              w_sync_bad = 1'b1;
              if (w_drop) begin
                w_state_nxt = S_HUNT;
                w_to_hunt   = 1'b1;
              end
            end
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, counters, byte assembly, strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr           <= '0;
      r_fill         <= '0;
      r_bit_cnt      <= '0;
      r_miss         <= '0;
      r_byte_sr      <= '0;
      r_byte_data    <= '0;
      r_byte_valid   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_sync_err_cnt <= '0;
      r_frame_cnt    <= '0;
    end else if (clr) begin
      r_sr           <= '0;
      r_fill         <= '0;
      r_bit_cnt      <= '0;
      r_miss         <= '0;
      r_byte_sr      <= '0;
      r_byte_data    <= '0;
      r_byte_valid   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_sync_err_cnt <= '0;
      r_frame_cnt    <= '0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      if (sample_en) begin
        r_sr <= w_nsr[SYNC_W-2:0];

        // Bit position restarts after every sync check, good or bad.
        if (r_state == S_HUNT) begin
          r_bit_cnt <= '0;
          if (r_fill != c_FILL_FULL) begin
            r_fill <= r_fill + 1'b1;
          end
        end else begin
          r_bit_cnt <= w_at_end ? '0 : w_idx;
        end

        // A window is already full when falling back to HUNT.
        if (w_to_hunt) begin
          r_fill <= c_FILL_FULL;
        end

        if ((r_state == S_LOCKED) && w_pay) begin
          r_byte_sr <= {r_byte_sr[5:0], bit_in};
          if (w_byte_end) begin
            r_byte_data  <= {r_byte_sr, bit_in};
            r_byte_valid <= 1'b1;
          end
        end

        if (w_lock_ok) begin
          r_miss <= '0;
        end

        if (w_sync_good) begin
          r_frame_start <= 1'b1;
          r_frame_cnt   <= r_frame_cnt + 1'b1;
          r_miss        <= '0;
        end

        if (w_sync_bad) begin
          r_miss <= w_miss_inc;
          if (r_sync_err_cnt != 8'hFF) begin
            r_sync_err_cnt <= r_sync_err_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign locked       = r_locked;
  assign byte_data    = r_byte_data;
  assign byte_valid   = r_byte_valid;
  assign frame_start  = r_frame_start;
  assign sync_err_cnt = r_sync_err_cnt;
  assign frame_cnt    = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cdr_frame_sync.sv
// ============================================================================
// Module   : tb_cdr_frame_sync
// Brief    : Randomised self-checking bench for cdr_frame_sync against a
//            bit-history reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cdr_frame_sync;

  localparam int          SYNC_W      = 16;
  localparam logic [15:0] SYNC_WORD   = 16'hF628;
  localparam int          FRAME_BYTES = 4;
  localparam int          MAX_MISS    = 2;
  localparam int          PAY_BITS    = FRAME_BYTES * 8;
  localparam int          FRAME_LEN   = PAY_BITS + SYNC_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        bit_in = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_start;
  logic [7:0]  sync_err_cnt;
  logic [15:0] frame_cnt;

  cdr_frame_sync #(
    .SYNC_W      (SYNC_W),
    .SYNC_WORD   (SYNC_WORD),
    .FRAME_BYTES (FRAME_BYTES),
    .MAX_MISS    (MAX_MISS)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .bit_in       (bit_in),
    .clr          (clr),
    .locked       (locked),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .frame_start  (frame_start),
    .sync_err_cnt (sync_err_cnt),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted bit since reset/clr is kept in order;
  // sync windows and byte boundaries are positions in that history.
  bit          hist[$];
  int          m_mode;     // 0 hunting, 1 confirming, 2 locked
  int          anchor;     // history length at the last sync end
  int          m_miss;
  logic        exp_locked;
  logic        exp_bv;
  logic [7:0]  exp_bd;
  logic        exp_fs;
  int          exp_err;
  int          exp_fcnt;
  logic [7:0]  byte_log[$];
  int          gap_min = 3;
  int          gap_max = 3;

  task automatic model_reset();
    hist.delete();
    m_mode     = 0;
    anchor     = 0;
    m_miss     = 0;
    exp_locked = 1'b0;
    exp_bv     = 1'b0;
    exp_bd     = 8'h00;
    exp_fs     = 1'b0;
    exp_err    = 0;
    exp_fcnt   = 0;
  endtask

  function automatic bit window_match();
    int n;
    n = hist.size();
    if (n < SYNC_W) return 1'b0;
    for (int i = 0; i < SYNC_W; i++) begin
      if (hist[n - SYNC_W + i] != SYNC_WORD[SYNC_W - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit se, input bit b, input bit c);
    int n;
    int off;
    bit m;
    exp_bv = 1'b0;
    exp_fs = 1'b0;
    if (c) begin
      model_reset();
      return;
    end
    if (!se) return;
    hist.push_back(b);
    n = hist.size();
    m = window_match();
    case (m_mode)
      0: if (m) begin m_mode = 1; anchor = n; end
      1: if (n - anchor == FRAME_LEN) begin
           if (m) begin m_mode = 2; m_miss = 0; anchor = n; end
           else m_mode = 0;
         end
      default: begin
        off = n - anchor;
        if (off <= PAY_BITS && off % 8 == 0) begin
          for (int k = 0; k < 8; k++) exp_bd[7 - k] = hist[n - 8 + k];
          exp_bv = 1'b1;
        end
        if (off == FRAME_LEN) begin
          anchor = n;
          if (m) begin
            exp_fs   = 1'b1;
            exp_fcnt = (exp_fcnt + 1) % 65536;
            m_miss   = 0;
          end else begin
            if (exp_err < 255) exp_err++;
            m_miss++;
            if (m_miss >= MAX_MISS) m_mode = 0;
          end
        end
      end
    endcase
    exp_locked = (m_mode == 2);
  endtask

  task automatic compare_outputs();
    check("locked", locked, exp_locked);
    check("byte_valid", byte_valid, exp_bv);
    check("byte_data", byte_data, exp_bd);
    check("frame_start", frame_start, exp_fs);
    check("sync_err_cnt", sync_err_cnt, exp_err);
    check("frame_cnt", frame_cnt, exp_fcnt);
    if (byte_valid === 1'b1) byte_log.push_back(byte_data);
  endtask

  // One clock: check what the previous inputs produced, then drive new ones.
  task automatic cycle(input bit se, input bit b, input bit c);
    @(negedge clk);
    compare_outputs();
    sample_en = se;
    bit_in    = b;
    clr       = c;
    model_step(se, b, c);
  endtask

  task automatic send_bit(input bit b);
    int gap;
    gap = $urandom_range(gap_max, gap_min);
    for (int g = 0; g < gap; g++) cycle(1'b0, bit'($urandom), 1'b0);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_t2_sequence();
    send_word({16'h0, SYNC_WORD}, 16);
    send_word(32'h11223344, 32);
    send_word({16'h0, SYNC_WORD}, 16);
    send_word(32'hDEADBEEF, 32);
    send_word({16'h0, SYNC_WORD}, 16);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] w);
    check({tag, "_count"}, byte_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < byte_log.size()) check({tag, "_byte"}, byte_log[i], w[31 - 8 * i -: 8]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_bv"}, byte_valid, 0);
    check({tag, "_bd"}, byte_data, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_err"}, sync_err_cnt, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    compare_outputs();
    sample_en = 1'b0;
    clr       = 1'b0;
    bit_in    = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pay;
    logic [15:0] tail;
    logic [15:0] bad;

    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Idle with bit_in toggling and no strobe
    for (int i = 0; i < 20; i++) cycle(1'b0, bit'(i & 1), 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_all_zero("idle");

    // Nominal lock sequence, one bit every 4 clocks
    gap_min = 3; gap_max = 3;
    byte_log.delete();
    send_word({16'h0, SYNC_WORD}, 16);
    send_word(32'h11223344, 32);
    send_word({16'h0, SYNC_WORD}, 16);
    cycle(1'b0, 1'b0, 1'b0);
    check("t2_locked_after_sync2", locked, 1);
    check("t2_confirm_no_bytes", byte_log.size(), 0);
    send_word(32'hDEADBEEF, 32);
    send_word({16'h0, SYNC_WORD}, 16);
    cycle(1'b0, 1'b0, 1'b0);
    check_bytes("t2", 32'hDEADBEEF);
    check("t2_frame_cnt", frame_cnt, 1);

    // Flywheel over one bad sync, recovery, then loss after two
    byte_log.delete();
    pay = $urandom;
    send_word(pay, 32);
    send_word({16'h0, SYNC_WORD ^ 16'h0001}, 16);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_locked_flywheel", locked, 1);
    check("t3_err1", sync_err_cnt, 1);
    check_bytes("t3_fly", pay);
    send_word($urandom, 32);
    send_word({16'h0, SYNC_WORD}, 16);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_fcnt2", frame_cnt, 2);
    send_word($urandom, 32);
    send_word({16'h0, SYNC_WORD ^ 16'h0001}, 16);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_locked_after_miss1", locked, 1);
    send_word($urandom, 32);
    send_word({16'h0, SYNC_WORD ^ 16'h8000}, 16);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_unlocked", locked, 0);
    check("t3_err3", sync_err_cnt, 3);

    // Lone sync inside random data: confirm must fail
    byte_log.delete();
    send_word($urandom, 20);
    send_word({16'h0, SYNC_WORD}, 16);
    send_word($urandom, 32);
    tail = 16'($urandom);
    if (tail == SYNC_WORD) tail = tail ^ 16'h0100;
    send_word({16'h0, tail}, 16);
    send_word($urandom, 24);
    cycle(1'b0, 1'b0, 1'b0);
    check("t4_not_locked", locked, 0);
    check("t4_no_bytes", byte_log.size(), 0);

    // Irregular strobe spacing gives the same byte stream
    cycle(1'b0, 1'b0, 1'b1);
    gap_min = 0; gap_max = 6;
    byte_log.delete();
    send_t2_sequence();
    check_bytes("t5", 32'hDEADBEEF);
    check("t5_fcnt", frame_cnt, 1);

    // Soft clear mid-payload together with a strobe
    gap_min = 0; gap_max = 2;
    send_word($urandom, 13);
    cycle(1'b1, bit'($urandom), 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check_all_zero("t6_clr");
    byte_log.delete();
    send_word(32'h0, 24);
    send_t2_sequence();
    check_bytes("t6_clr_relock", 32'hDEADBEEF);

    // Asynchronous reset mid-frame
    send_word($urandom, 10);
    hard_reset();
    byte_log.delete();
    send_word(32'h0, 12);
    send_t2_sequence();
    check_bytes("t6_rst_relock", 32'hDEADBEEF);

    // Long random run with occasional corrupted syncs
    cycle(1'b0, 1'b0, 1'b1);
    gap_min = 0; gap_max = 3;
    for (int f = 0; f < 40; f++) begin
      bad = SYNC_WORD;
      if ($urandom_range(4, 0) == 0) bad = SYNC_WORD ^ (16'h1 << $urandom_range(15, 0));
      send_word({16'h0, bad}, 16);
      send_word($urandom, 32);
    end
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
